// File: rtl/sccb_master.sv
// SCCB master: 3-phase register writes and 2+2-phase register reads on SIO_C/SIO_D.
// state | meaning
// IDLE  | lines parked high, waiting for cmdStart
// START | start condition, SIO_D falls while SIO_C high
// BITS  | 9-bit slots of each byte (8 data bits + ack/NA)
// STOP  | stop condition, SIO_D rises while SIO_C high
module sccb_master #(
    parameter int QTR_CYCLES = 25
) (
    input  logic       sccbClk,
    input  logic       sccbReset,
    input  logic       cmdStart,
    input  logic       cmdRead,
    input  logic [6:0] cmdId,
    input  logic [7:0] cmdAddr,
    input  logic [7:0] cmdWData,
    output logic       busy,
    output logic       done,
    output logic [7:0] rData,
    output logic       nack,
    output logic       sioC,
    output logic       sioDOut,
    output logic       sioDOe,
    input  logic       sioDIn
);

    typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;

    localparam logic [7:0] QTR_LAST = 8'(QTR_CYCLES - 1);

    state_t     state;
    logic [7:0] qCnt;
    logic [1:0] quarter;
    logic [3:0] bitIdx;
    logic [1:0] byteIdx;
    logic       half;

    logic       rdLat;
    logic [6:0] idLat;
    logic [7:0] addrLat;
    logic [7:0] wDataLat;
    logic       nackAcc;
    logic [7:0] rdShift;
    logic       sioMeta;
    logic       sioSync;

    logic       lastBit;
    logic       lastByte;
    logic       readByte;
    logic [3:0] nxtBit;
    logic [1:0] nxtByte;
    logic [7:0] txByte;
    logic       nxtRdByte;
    logic       nxtOe;
    logic       nxtOut;

    // Drive values for the slot that follows the current one.
    always_comb begin
        lastBit   = (bitIdx == 4'd8);
        lastByte  = rdLat ? (byteIdx == 2'd1) : (byteIdx == 2'd2);
        readByte  = rdLat && half && (byteIdx == 2'd1);
        nxtBit    = lastBit ? 4'd0 : bitIdx + 4'd1;
        nxtByte   = lastBit ? byteIdx + 2'd1 : byteIdx;
        nxtRdByte = rdLat && half && (nxtByte == 2'd1);
        case (nxtByte)
            2'd0:    txByte = {idLat, rdLat & half};
            2'd1:    txByte = addrLat;
            default: txByte = wDataLat;
        endcase
        nxtOut = 1'b1;
        nxtOe  = 1'b1;
        if (nxtBit == 4'd8) begin
            nxtOe = nxtRdByte;
        end else if (nxtRdByte) begin
            nxtOe = 1'b0;
        end else begin
            nxtOut = txByte[3'd7 - nxtBit[2:0]];
        end
    end

    always_ff @(posedge sccbClk or posedge sccbReset) begin
        if (sccbReset) begin
            state    <= IDLE;
            qCnt     <= '0;
            quarter  <= '0;
            bitIdx   <= '0;
            byteIdx  <= '0;
            half     <= 1'b0;
            rdLat    <= 1'b0;
            idLat    <= '0;
            addrLat  <= '0;
            wDataLat <= '0;
            nackAcc  <= 1'b0;
            rdShift  <= '0;
            sioMeta  <= 1'b1;
            sioSync  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rData    <= '0;
            nack     <= 1'b0;
            sioC     <= 1'b1;
            sioDOut  <= 1'b1;
            sioDOe   <= 1'b1;
        end else begin
            done    <= 1'b0;
            sioMeta <= sioDIn;
            sioSync <= sioMeta;
            if (state == IDLE) begin
                if (cmdStart) begin
                    rdLat    <= cmdRead;
                    idLat    <= cmdId;
                    addrLat  <= cmdAddr;
                    wDataLat <= cmdWData;
                    nackAcc  <= 1'b0;
                    half     <= 1'b0;
                    busy     <= 1'b1;
                    state    <= START;
                    quarter  <= 2'd0;
                    qCnt     <= QTR_LAST;
                end
            end else if (qCnt != 8'd0) begin
                qCnt <= qCnt - 8'd1;
            end else begin
                qCnt    <= QTR_LAST;
                quarter <= quarter + 2'd1;
                case (state)
                    START: begin
                        if (quarter == 2'd1) sioDOut <= 1'b0;
                        if (quarter == 2'd3) begin
                            state   <= BITS;
                            bitIdx  <= 4'd0;
                            byteIdx <= 2'd0;
                            sioC    <= 1'b0;
                            sioDOut <= idLat[6];
                            sioDOe  <= 1'b1;
                        end
                    end
                    BITS: begin
                        case (quarter)
                            2'd1: sioC <= 1'b1;
                            // End of Q2: the synchronized pad value is taken here.
                            2'd2: begin
                                if (lastBit && !readByte) begin
                                    nackAcc <= nackAcc | sioSync;
                                end else if (readByte && !lastBit) begin
                                    rdShift <= {rdShift[6:0], sioSync};
                                end
                            end
                            2'd3: begin
                                sioC <= 1'b0;
                                if (lastBit && lastByte) begin
                                    state   <= STOP;
                                    sioDOut <= 1'b0;
                                    sioDOe  <= 1'b1;
                                end else begin
                                    bitIdx  <= nxtBit;
                                    byteIdx <= nxtByte;
                                    sioDOut <= nxtOut;
                                    sioDOe  <= nxtOe;
                                end
                            end
                            default: ;
                        endcase
                    end
                    STOP: begin
                        case (quarter)
                            2'd1: sioC <= 1'b1;
                            2'd2: sioDOut <= 1'b1;
                            2'd3: begin
                                if (rdLat && !half) begin
                                    half  <= 1'b1;
                                    state <= START;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    nack  <= nackAcc;
                                    if (rdLat) rData <= rdShift;
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_master.sv
// Scoreboarded bench for sccb_master with a behavioural SCCB slave on the bus.
module tb_sccb_master;
    localparam int Q    = 4;
    localparam int EV_S = 256;
    localparam int EV_P = 257;

    logic       sccbClk = 1'b0;
    logic       sccbReset = 1'b1;
    logic       cmdStart = 1'b0;
    logic       cmdRead = 1'b0;
    logic [6:0] cmdId = '0;
    logic [7:0] cmdAddr = '0;
    logic [7:0] cmdWData = '0;
    logic       busy, done, nack, sioC, sioDOut, sioDOe, sioDIn;
    logic [7:0] rData;
    logic       slaveDrv = 1'b1;

    assign sioDIn = sioDOe ? sioDOut : slaveDrv;

    sccb_master #(.QTR_CYCLES(Q)) dut (
        .sccbClk(sccbClk), .sccbReset(sccbReset), .cmdStart(cmdStart), .cmdRead(cmdRead),
        .cmdId(cmdId), .cmdAddr(cmdAddr), .cmdWData(cmdWData), .busy(busy), .done(done),
        .rData(rData), .nack(nack), .sioC(sioC), .sioDOut(sioDOut), .sioDOe(sioDOe),
        .sioDIn(sioDIn)
    );

    always #5 sccbClk = ~sccbClk;

    typedef struct packed {
        logic [7:0]  rData;
        logic        nack;
        logic [15:0] len;
    } exp_t;

    exp_t       expQ[$];
    int         expEv[$];
    logic       ackQ[$];
    logic [7:0] dataQ[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] modelRData = '0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference model: what the bus and the result registers must show for one command.
    task automatic queueTxn(input logic rd, input logic [6:0] id, input logic [7:0] addr,
                            input logic [7:0] wd, input logic [2:0] acks, input logic [7:0] data);
        exp_t e;
        ackQ.push_back(acks[0]);
        ackQ.push_back(acks[1]);
        ackQ.push_back(acks[2]);
        expEv.push_back(EV_S);
        expEv.push_back(int'(id) * 2);
        expEv.push_back(int'(addr));
        if (rd) begin
            expEv.push_back(EV_P);
            expEv.push_back(EV_S);
            expEv.push_back(int'(id) * 2 + 1);
            expEv.push_back(int'(data));
            dataQ.push_back(data);
            modelRData = data;
        end else begin
            expEv.push_back(int'(wd));
        end
        expEv.push_back(EV_P);
        e.rData = modelRData;
        e.nack  = |acks;
        e.len   = 16'(rd ? 160 * Q : 116 * Q);
        expQ.push_back(e);
    endtask

    task automatic scrambleFields();
        cmdRead  = 1'($urandom);
        cmdId    = 7'($urandom);
        cmdAddr  = 8'($urandom);
        cmdWData = 8'($urandom);
    endtask

    task automatic waitFree();
        int n = 0;
        @(negedge sccbClk); #1;
        while (busy && n < 3000) begin
            @(negedge sccbClk); #1;
            n++;
        end
        if (busy) failNow("wait_free");
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge sccbClk); #1;
        while ((busy || expQ.size() != 0) && n < 3000) begin
            @(negedge sccbClk); #1;
            n++;
        end
        if (busy || expQ.size() != 0) failNow("wait_idle");
    endtask

    task automatic doTxn(input logic rd, input logic [6:0] id, input logic [7:0] addr,
                         input logic [7:0] wd, input logic [2:0] acks, input logic [7:0] data);
        queueTxn(rd, id, addr, wd, acks, data);
        waitFree();
        cmdRead  = rd;
        cmdId    = id;
        cmdAddr  = addr;
        cmdWData = wd;
        cmdStart = 1'b1;
        @(posedge sccbClk); #1;
        cmdStart = 1'b0;
        scrambleFields();
    endtask

    // Slave + monitor, evaluated away from the active edge.
    int         bitCnt = 0;
    int         byteCnt = 0;
    int         busyCnt = 0;
    logic       rdMode = 1'b0;
    logic       active = 1'b0;
    logic       prevC = 1'b1;
    logic       prevD = 1'b1;
    logic [7:0] sh = '0;
    logic [7:0] curRd = '0;

    task automatic gotEv(input int v);
        if (expEv.size() == 0) begin
            total++;
            bad++;
            $display("FAIL bus_event: got 0x%0h, want none", v);
        end else begin
            check("bus_event", v, expEv.pop_front());
        end
    endtask

    always @(negedge sccbClk) begin
        logic masterByte;
        exp_t e;
        if (sccbReset) begin
            active   = 1'b0;
            slaveDrv = 1'b1;
            busyCnt  = 0;
            prevC    = sioC;
            prevD    = sioDIn;
        end else begin
            if (busy) busyCnt++;
            if (done) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done, want none");
                end else begin
                    e = expQ.pop_front();
                    check("done_rData", int'(rData), int'(e.rData));
                    check("done_nack", int'(nack), int'(e.nack));
                    check("busy_len", busyCnt, int'(e.len));
                    check("idle_lines", int'({sioC, sioDOut, sioDOe}), 7);
                end
                busyCnt = 0;
            end
            masterByte = !(rdMode && byteCnt == 1);
            if (prevC && sioC && prevD && !sioDIn) begin
                active  = 1'b1;
                bitCnt  = 0;
                byteCnt = 0;
                rdMode  = 1'b0;
                gotEv(EV_S);
            end else if (prevC && sioC && !prevD && sioDIn) begin
                active = 1'b0;
                gotEv(EV_P);
            end else if (active && !prevC && sioC) begin
                if (bitCnt == 8) begin
                    check("oe_ninth", int'(sioDOe), masterByte ? 0 : 1);
                    if (!masterByte) check("na_bit", int'(sioDIn), 1);
                    gotEv(int'(sh));
                    if (byteCnt == 0) rdMode = sh[0];
                    byteCnt++;
                    bitCnt = 0;
                end else begin
                    check("oe_data", int'(sioDOe), masterByte ? 1 : 0);
                    sh = {sh[6:0], sioDIn};
                    bitCnt++;
                end
            end else if (active && prevC && !sioC) begin
                if (bitCnt == 8 && masterByte) begin
                    slaveDrv = (ackQ.size() != 0) ? ackQ.pop_front() : 1'b0;
                end else if (rdMode && byteCnt == 1 && bitCnt < 8) begin
                    if (bitCnt == 0) curRd = (dataQ.size() != 0) ? dataQ.pop_front() : 8'h00;
                    slaveDrv = curRd[7 - bitCnt];
                end else begin
                    slaveDrv = 1'b1;
                end
            end
            prevC = sioC;
            prevD = sioDIn;
        end
    end

    initial begin
        logic       rd;
        logic [2:0] acks;
        int         n;
        int         gap;

        repeat (3) @(posedge sccbClk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rData", int'(rData), 0);
        check("rst_nack", int'(nack), 0);
        check("rst_lines", int'({sioC, sioDOut, sioDOe}), 7);
        @(negedge sccbClk);
        sccbReset = 1'b0;

        doTxn(1'b0, 7'h21, 8'h12, 8'h80, 3'b000, 8'h00);
        waitIdle();
        doTxn(1'b1, 7'h21, 8'h0A, 8'h00, 3'b000, 8'hA5);
        waitIdle();
        doTxn(1'b0, 7'h3C, 8'h55, 8'h0F, 3'b010, 8'h00);
        waitIdle();
        doTxn(1'b0, 7'h3C, 8'h56, 8'hF0, 3'b000, 8'h00);
        waitIdle();

        // A start strobe with different fields in the middle of a read is ignored.
        doTxn(1'b1, 7'h45, 8'h9C, 8'h00, 3'b000, 8'h3E);
        repeat (100) @(negedge sccbClk);
        scrambleFields();
        cmdStart = 1'b1;
        @(posedge sccbClk); #1;
        cmdStart = 1'b0;
        waitIdle();

        // Back-to-back writes with cmdStart held high.
        queueTxn(1'b0, 7'h11, 8'h22, 8'h33, 3'b000, 8'h00);
        queueTxn(1'b0, 7'h6A, 8'hB5, 8'hC7, 3'b100, 8'h00);
        waitFree();
        cmdRead  = 1'b0;
        cmdId    = 7'h11;
        cmdAddr  = 8'h22;
        cmdWData = 8'h33;
        cmdStart = 1'b1;
        @(posedge sccbClk); #1;
        cmdId    = 7'h6A;
        cmdAddr  = 8'hB5;
        cmdWData = 8'hC7;
        n = 0;
        @(negedge sccbClk);
        while (busy && n < 3000) begin
            @(negedge sccbClk);
            n++;
        end
        gap = 0;
        while (!busy && gap < 10) begin
            gap++;
            @(negedge sccbClk);
        end
        cmdStart = 1'b0;
        check("b2b_gap", gap, 1);
        waitIdle();

        for (int i = 0; i < 12; i++) begin
            rd   = 1'($urandom);
            acks = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            doTxn(rd, 7'($urandom), 8'($urandom), 8'($urandom), acks, 8'($urandom));
        end
        waitIdle();

        // Leave nack=1 and a nonzero rData behind, then reset during the address byte.
        doTxn(1'b1, 7'h2B, 8'h71, 8'h00, 3'b001, 8'h5A);
        waitIdle();
        doTxn(1'b0, 7'h21, 8'h34, 8'h99, 3'b000, 8'h00);
        repeat (200) @(negedge sccbClk);
        #2;
        sccbReset = 1'b1;
        #1;
        check("midrst_lines", int'({sioC, sioDOut, sioDOe}), 7);
        check("midrst_busy", int'(busy), 0);
        check("midrst_rData", int'(rData), 0);
        check("midrst_nack", int'(nack), 0);
        expQ.delete();
        expEv.delete();
        ackQ.delete();
        dataQ.delete();
        modelRData = 8'h00;
        repeat (3) @(posedge sccbClk);
        @(negedge sccbClk);
        sccbReset = 1'b0;
        doTxn(1'b0, 7'h21, 8'h12, 8'h80, 3'b000, 8'h00);
        waitIdle();

        check("expq_empty", expQ.size(), 0);
        check("events_empty", expEv.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
